// File: rtl/wbs_mem_ctrl.sv
// Wishbone slave bridging the management bus to the accelerator's registers, query/leaf
// SRAMs, best-match array and node tree. Optional feature macro: WBS_REG_READBACK_EN.
module wbs_mem_ctrl #(
  parameter int DATA_WIDTH = 11,
  parameter int LEAF_SIZE  = 8,
  parameter int PATCH_SIZE = 5,
  parameter int ROW_SIZE   = 24,
  parameter int COL_SIZE   = 17,
  parameter int K          = 4,
  parameter int NUM_LEAVES = 64,
  parameter int NUM_QUERYS = ROW_SIZE * COL_SIZE,
  parameter int QADDRW     = $clog2(NUM_QUERYS),
  parameter int LEAF_ADDRW = $clog2(NUM_LEAVES)
) (
  input  logic                             wb_clk_i,
  input  logic                             rst_n,
  input  logic                             wbs_stb_i,
  input  logic                             wbs_cyc_i,
  input  logic                             wbs_we_i,
  input  logic [3:0]                       wbs_sel_i,
  input  logic [31:0]                      wbs_dat_i,
  input  logic [31:0]                      wbs_adr_i,
  output logic                             wbs_ack_o,
  output logic [31:0]                      wbs_dat_o,
  output logic                             wbs_mode,
  output logic                             wbs_debug,
  output logic                             wbs_qp_mem_csb0,
  output logic                             wbs_qp_mem_web0,
  output logic [QADDRW-1:0]                wbs_qp_mem_addr0,
  output logic [PATCH_SIZE*DATA_WIDTH-1:0] wbs_qp_mem_wpatch0,
  input  logic [PATCH_SIZE*DATA_WIDTH-1:0] wbs_qp_mem_rpatch0,
  output logic [LEAF_SIZE-1:0]             wbs_leaf_mem_csb0,
  output logic [LEAF_SIZE-1:0]             wbs_leaf_mem_web0,
  output logic [LEAF_ADDRW-1:0]            wbs_leaf_mem_addr0,
  output logic [63:0]                      wbs_leaf_mem_wleaf0,
  input  logic [LEAF_SIZE*64-1:0]          wbs_leaf_mem_rleaf0,
  output logic                             wbs_node_mem_web,
  output logic [31:0]                      wbs_node_mem_addr,
  output logic [31:0]                      wbs_node_mem_wdata,
  input  logic [31:0]                      wbs_node_mem_rdata,
  output logic                             wbs_best_arr_csb1,
  output logic [7:0]                       wbs_best_arr_addr1,
  input  logic [63:0]                      wbs_best_arr_rdata1
);

  localparam int QW  = PATCH_SIZE * DATA_WIDTH;
  localparam int LBW = $clog2(LEAF_SIZE);
  localparam logic [31:0] K_COMPAT = K;

  typedef enum logic [1:0] {S_IDLE, S_MEM, S_WAIT, S_ACK} state_e;
  typedef enum logic [2:0] {R_REG, R_QRY, R_LEAF, R_BEST, R_NODE, R_NONE} region_e;

  state_e                  state_q;
  region_e                 region_q, region_d;
  logic                    we_q;
  logic                    upper_q;
  logic [LBW-1:0]          bank_q, bank_d;
  logic [31:0]             hold_q;
  logic                    ack_q;
  logic [31:0]             dat_o_q;
  logic                    mode_q, debug_q;
  logic                    qp_csb_q, qp_web_q;
  logic [QADDRW-1:0]       qp_addr_q;
  logic [QW-1:0]           qp_wpatch_q;
  logic [LEAF_SIZE-1:0]    leaf_csb_q, leaf_web_q;
  logic [LEAF_ADDRW-1:0]   leaf_addr_q;
  logic [63:0]             leaf_wleaf_q;
  logic                    node_web_q;
  logic [31:0]             node_addr_q, node_wdata_q;
  logic                    best_csb_q;
  logic [7:0]              best_addr_q;

  logic [13:0]             reg_word;
  logic [31:0]             reg_rdata_d;
  logic [31:0]             rd_data_d;
  logic [63:0]             leaf_word, best_word;
  logic                    unused_ok;

  assign unused_ok = &{1'b0, wbs_sel_i, wbs_adr_i[1:0], K_COMPAT[0]};
  assign reg_word  = wbs_adr_i[15:2];
  assign bank_d    = wbs_adr_i[3 +: LBW];

  // Out-of-range offsets inside a region decode as unmapped so they cannot strobe a memory.
  always_comb begin
    region_d = R_NONE;
    case (wbs_adr_i[31:16])
      16'h3000: if (reg_word <= 14'd2) region_d = R_REG;
      16'h3001: if ((wbs_adr_i[15:0] >> (3 + QADDRW)) == 16'd0 &&
                    {1'b0, wbs_adr_i[3 +: QADDRW]} < (QADDRW + 1)'(NUM_QUERYS)) region_d = R_QRY;
      16'h3002: if ((wbs_adr_i[15:0] >> (3 + LBW + LEAF_ADDRW)) == 16'd0) region_d = R_LEAF;
      16'h3003: if ((wbs_adr_i[15:0] >> 11) == 16'd0) region_d = R_BEST;
      16'h3004: region_d = R_NODE;
      default:  region_d = R_NONE;
    endcase
  end

  always_comb begin
    reg_rdata_d = '0;
`ifdef WBS_REG_READBACK_EN
    if (reg_word == 14'd0) reg_rdata_d = {31'b0, mode_q};
    if (reg_word == 14'd1) reg_rdata_d = {31'b0, debug_q};
`endif
  end

  // NOTE: every variable written in always_comb gets a default first, or a latch is inferred.
  always_comb begin
    leaf_word = wbs_leaf_mem_rleaf0[{bank_q, 6'd0} +: 64];
    best_word = wbs_best_arr_rdata1;
    rd_data_d = '0;
    case (region_q)
      R_QRY:   rd_data_d = upper_q ? 32'(wbs_qp_mem_rpatch0[QW-1:32]) : wbs_qp_mem_rpatch0[31:0];
      R_LEAF:  rd_data_d = upper_q ? leaf_word[63:32] : leaf_word[31:0];
      R_BEST:  rd_data_d = upper_q ? best_word[63:32] : best_word[31:0];
      R_NODE:  rd_data_d = wbs_node_mem_rdata;
      default: rd_data_d = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge wb_clk_i) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      region_q     <= R_NONE;
      we_q         <= 1'b0;
      upper_q      <= 1'b0;
      bank_q       <= '0;
      hold_q       <= '0;
      ack_q        <= 1'b0;
      dat_o_q      <= '0;
      mode_q       <= 1'b0;
      debug_q      <= 1'b0;
      qp_csb_q     <= 1'b1;
      qp_web_q     <= 1'b1;
      qp_addr_q    <= '0;
      qp_wpatch_q  <= '0;
      leaf_csb_q   <= '1;
      leaf_web_q   <= '1;
      leaf_addr_q  <= '0;
      leaf_wleaf_q <= '0;
      node_web_q   <= 1'b0;
      node_addr_q  <= '0;
      node_wdata_q <= '0;
      best_csb_q   <= 1'b1;
      best_addr_q  <= '0;
    end else begin
      // Strobes and ack default inactive so each asserts for exactly one cycle.
      ack_q      <= 1'b0;
      qp_csb_q   <= 1'b1;
      qp_web_q   <= 1'b1;
      leaf_csb_q <= '1;
      leaf_web_q <= '1;
      node_web_q <= 1'b0;
      best_csb_q <= 1'b1;
      unique case (state_q)
        S_IDLE: if (wbs_cyc_i && wbs_stb_i) begin
          region_q <= region_d;
          we_q     <= wbs_we_i;
          upper_q  <= wbs_adr_i[2];
          bank_q   <= bank_d;
          case (region_d)
            R_REG: begin
              if (wbs_we_i) begin
                if (reg_word == 14'd0) mode_q  <= wbs_dat_i[0];
                if (reg_word == 14'd1) debug_q <= wbs_dat_i[0];
              end else begin
                dat_o_q <= reg_rdata_d;
              end
              ack_q   <= 1'b1;
              state_q <= S_ACK;
            end
            R_QRY: begin
              qp_addr_q <= wbs_adr_i[3 +: QADDRW];
              if (wbs_we_i && !wbs_adr_i[2]) begin
                hold_q  <= wbs_dat_i;
                ack_q   <= 1'b1;
                state_q <= S_ACK;
              end else begin
                qp_csb_q <= 1'b0;
                if (wbs_we_i) begin
                  qp_web_q    <= 1'b0;
                  qp_wpatch_q <= {wbs_dat_i[QW-33:0], hold_q};
                end
                state_q <= S_MEM;
              end
            end
            R_LEAF: begin
              leaf_addr_q <= wbs_adr_i[3 + LBW +: LEAF_ADDRW];
              if (wbs_we_i && !wbs_adr_i[2]) begin
                hold_q  <= wbs_dat_i;
                ack_q   <= 1'b1;
                state_q <= S_ACK;
              end else begin
                leaf_csb_q[bank_d] <= 1'b0;
                if (wbs_we_i) begin
                  leaf_web_q[bank_d] <= 1'b0;
                  leaf_wleaf_q       <= {wbs_dat_i, hold_q};
                end
                state_q <= S_MEM;
              end
            end
            R_BEST: begin
              if (wbs_we_i) begin
                ack_q   <= 1'b1;
                state_q <= S_ACK;
              end else begin
                best_addr_q <= wbs_adr_i[10:3];
                best_csb_q  <= 1'b0;
                state_q     <= S_MEM;
              end
            end
            R_NODE: begin
              node_addr_q <= {16'b0, wbs_adr_i[15:0]};
              if (wbs_we_i) begin
                node_web_q   <= 1'b1;
                node_wdata_q <= wbs_dat_i;
              end
              state_q <= S_MEM;
            end
            default: begin
              if (!wbs_we_i) dat_o_q <= '0;
              ack_q   <= 1'b1;
              state_q <= S_ACK;
            end
          endcase
        end
        S_MEM: begin
          if (we_q) begin
            ack_q   <= 1'b1;
            state_q <= S_ACK;
          end else begin
            state_q <= S_WAIT;
          end
        end
        // Capturing one cycle after the strobe tolerates an SRAM that answers a cycle late.
        S_WAIT: begin
          dat_o_q <= rd_data_d;
          ack_q   <= 1'b1;
          state_q <= S_ACK;
        end
        S_ACK: state_q <= S_IDLE;
      endcase
    end
  end

  assign wbs_ack_o           = ack_q;
  assign wbs_dat_o           = dat_o_q;
  assign wbs_mode            = mode_q;
  assign wbs_debug           = debug_q;
  assign wbs_qp_mem_csb0     = qp_csb_q;
  assign wbs_qp_mem_web0     = qp_web_q;
  assign wbs_qp_mem_addr0    = qp_addr_q;
  assign wbs_qp_mem_wpatch0  = qp_wpatch_q;
  assign wbs_leaf_mem_csb0   = leaf_csb_q;
  assign wbs_leaf_mem_web0   = leaf_web_q;
  assign wbs_leaf_mem_addr0  = leaf_addr_q;
  assign wbs_leaf_mem_wleaf0 = leaf_wleaf_q;
  assign wbs_node_mem_web    = node_web_q;
  assign wbs_node_mem_addr   = node_addr_q;
  assign wbs_node_mem_wdata  = node_wdata_q;
  assign wbs_best_arr_csb1   = best_csb_q;
  assign wbs_best_arr_addr1  = best_addr_q;

endmodule

// File: tb/tb_wbs_mem_ctrl.sv
// Directed bench for wbs_mem_ctrl: fixed SRAM read data, a small node-tree model and
// strobe monitors; expected values are hand-computed constants.
module tb_wbs_mem_ctrl;

  localparam int LEAF_SIZE = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'hF;
  logic [31:0] dat_i = '0, adr = '0;
  logic        ack, mode, debug;
  logic [31:0] dat_o;
  logic        qp_csb, qp_web;
  logic [8:0]  qp_addr;
  logic [54:0] qp_wpatch;
  logic [54:0] qp_rpatch = '0;
  logic [LEAF_SIZE-1:0] leaf_csb, leaf_web;
  logic [5:0]  leaf_addr;
  logic [63:0] leaf_wleaf;
  logic [LEAF_SIZE*64-1:0] leaf_rleaf = '0;
  logic        node_web;
  logic [31:0] node_addr, node_wdata, node_rdata;
  logic        best_csb;
  logic [7:0]  best_addr;
  logic [63:0] best_rdata = '0;

  wbs_mem_ctrl dut (
    .wb_clk_i            (clk),
    .rst_n               (rst_n),
    .wbs_stb_i           (stb),
    .wbs_cyc_i           (cyc),
    .wbs_we_i            (we),
    .wbs_sel_i           (sel),
    .wbs_dat_i           (dat_i),
    .wbs_adr_i           (adr),
    .wbs_ack_o           (ack),
    .wbs_dat_o           (dat_o),
    .wbs_mode            (mode),
    .wbs_debug           (debug),
    .wbs_qp_mem_csb0     (qp_csb),
    .wbs_qp_mem_web0     (qp_web),
    .wbs_qp_mem_addr0    (qp_addr),
    .wbs_qp_mem_wpatch0  (qp_wpatch),
    .wbs_qp_mem_rpatch0  (qp_rpatch),
    .wbs_leaf_mem_csb0   (leaf_csb),
    .wbs_leaf_mem_web0   (leaf_web),
    .wbs_leaf_mem_addr0  (leaf_addr),
    .wbs_leaf_mem_wleaf0 (leaf_wleaf),
    .wbs_leaf_mem_rleaf0 (leaf_rleaf),
    .wbs_node_mem_web    (node_web),
    .wbs_node_mem_addr   (node_addr),
    .wbs_node_mem_wdata  (node_wdata),
    .wbs_node_mem_rdata  (node_rdata),
    .wbs_best_arr_csb1   (best_csb),
    .wbs_best_arr_addr1  (best_addr),
    .wbs_best_arr_rdata1 (best_rdata)
  );

  // Node tree model: written on the web strobe, read combinationally by word index.
  logic [31:0] node_mem [64];
  assign node_rdata = node_mem[node_addr[5:0]];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) node_mem[i] <= '0;
    end else if (node_web) begin
      node_mem[node_addr[5:0]] <= node_wdata;
    end
  end

  // Strobe monitors sampled mid-cycle.
  int          qp_rd_n = 0, qp_wr_n = 0, leaf_rd_n = 0, leaf_wr_n = 0, best_rd_n = 0, node_wr_n = 0;
  logic [8:0]  qp_addr_seen = '0;
  logic [54:0] qp_wpatch_seen = '0;
  logic [7:0]  leaf_csb_seen = '0, leaf_web_seen = '0, best_addr_seen = '0;
  logic [63:0] leaf_wleaf_seen = '0;
  logic [31:0] node_addr_seen = '0, node_wdata_seen = '0;
  always @(negedge clk) begin
    if (!qp_csb) begin
      qp_addr_seen <= qp_addr;
      if (qp_web) qp_rd_n <= qp_rd_n + 1;
      else begin
        qp_wr_n        <= qp_wr_n + 1;
        qp_wpatch_seen <= qp_wpatch;
      end
    end
    if (leaf_csb != '1) begin
      leaf_csb_seen <= leaf_csb;
      leaf_web_seen <= leaf_web;
      if (leaf_web == '1) leaf_rd_n <= leaf_rd_n + 1;
      else begin
        leaf_wr_n       <= leaf_wr_n + 1;
        leaf_wleaf_seen <= leaf_wleaf;
      end
    end
    if (!best_csb) begin
      best_rd_n      <= best_rd_n + 1;
      best_addr_seen <= best_addr;
    end
    if (node_web) begin
      node_wr_n       <= node_wr_n + 1;
      node_addr_seen  <= node_addr;
      node_wdata_seen <= node_wdata;
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One Wishbone transfer; lat counts clock edges from the request edge to the ack cycle.
  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] rd, output int lat);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!ack && lat < 10);
    rd  = dat_o;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    check("ack_one_cycle", ack, 1'b0);
  endtask

  logic [31:0] rd;
  int          lat;
  int          n0, n1;
  logic        exp_rb;

  initial begin
    qp_rpatch = 55'h00_1010_DEAD_BEEF;
    for (int b = 0; b < LEAF_SIZE; b++) leaf_rleaf[b*64 +: 64] = {32'hB0B0_0000 + 32'(b), 32'h5A5A_0000 + 32'(b)};
    leaf_rleaf[7*64 +: 64] = 64'h1100_1010_DEAD_BEEF;
    best_rdata = 64'h1100_1010_DEAD_BEEF;

    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("rst_mode_debug_ack", {mode, debug, ack}, 3'b000);
    check("rst_dat_o", dat_o, 32'h0);
    check("rst_csb_web", {qp_csb, qp_web, leaf_csb, leaf_web, best_csb, node_web}, {1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1, 1'b0});
    check("rst_addrs", {qp_addr, leaf_addr, best_addr, node_addr}, '0);
    check("rst_wdata", {qp_wpatch, node_wdata}, '0);
    check("rst_wleaf", leaf_wleaf, 64'h0);

    // Registers
    wb_xfer(1'b1, 32'h3000_0004, 32'h1, rd, lat);
    check("debug_wr_lat", lat, 1);
    check("debug_set", debug, 1'b1);
    wb_xfer(1'b1, 32'h3000_0000, 32'h1, rd, lat);
    check("mode_wr_lat", lat, 1);
    wb_xfer(1'b1, 32'h3000_0004, 32'h0, rd, lat);
    check("debug_clr_lat", lat, 1);
    check("mode_debug_final", {mode, debug}, 2'b10);
`ifdef WBS_REG_READBACK_EN
    exp_rb = 1'b1;
`else
    exp_rb = 1'b0;
`endif
    wb_xfer(1'b0, 32'h3000_0000, 32'h0, rd, lat);
    check("mode_rd_lat", lat, 1);
    check("mode_rd", rd, {31'b0, exp_rb});
    wb_xfer(1'b1, 32'h3000_0008, 32'hFFFF_FFFF, rd, lat);
    wb_xfer(1'b0, 32'h3000_0008, 32'h0, rd, lat);
    check("done_rd", rd, 32'h0);
    check("done_wr_no_effect", {mode, debug}, 2'b10);

    // Query SRAM read, both halves
    n0 = qp_rd_n; n1 = qp_wr_n;
    wb_xfer(1'b0, 32'h3001_0008, 32'h0, rd, lat);
    check("qp_rd_lat", lat, 3);
    check("qp_rd_lo", rd, 32'hDEAD_BEEF);
    check("qp_rd_strobes", qp_rd_n - n0, 1);
    check("qp_rd_addr", qp_addr_seen, 9'd1);
    wb_xfer(1'b0, 32'h3001_000C, 32'h0, rd, lat);
    check("qp_rd_hi", rd, 32'h0000_1010);
    check("qp_rd_no_write", qp_wr_n - n1, 0);

    // Query write: lower half holds, upper half commits
    n1 = qp_wr_n;
    wb_xfer(1'b1, 32'h3001_0010, 32'h0123_4567, rd, lat);
    check("qp_wr_lo_lat", lat, 1);
    check("qp_wr_lo_no_strobe", qp_wr_n - n1, 0);
    wb_xfer(1'b1, 32'h3001_0014, 32'h000B_CDEF, rd, lat);
    check("qp_wr_hi_lat", lat, 2);
    check("qp_wr_strobes", qp_wr_n - n1, 1);
    check("qp_wr_addr", qp_addr_seen, 9'd2);
    check("qp_wpatch", qp_wpatch_seen, 55'h0B_CDEF_0123_4567);

    // Leaf read from bank 7
    n0 = leaf_rd_n;
    wb_xfer(1'b0, 32'h3002_0038, 32'h0, rd, lat);
    check("leaf_rd_lat", lat, 3);
    check("leaf_rd_csb", leaf_csb_seen, 8'h7F);
    check("leaf_rd_lo", rd, 32'hDEAD_BEEF);
    wb_xfer(1'b0, 32'h3002_003C, 32'h0, rd, lat);
    check("leaf_rd_hi", rd, 32'h1100_1010);
    check("leaf_rd_strobes", leaf_rd_n - n0, 2);

    // Leaf write to bank 2, row 1
    n1 = leaf_wr_n;
    wb_xfer(1'b1, 32'h3002_0050, 32'hCAFE_F00D, rd, lat);
    wb_xfer(1'b1, 32'h3002_0054, 32'h1234_5678, rd, lat);
    check("leaf_wr_lat", lat, 2);
    check("leaf_wr_strobes", leaf_wr_n - n1, 1);
    check("leaf_wr_csb_web", {leaf_csb_seen, leaf_web_seen}, 16'hFBFB);
    check("leaf_wr_addr", leaf_addr, 6'd1);
    check("leaf_wleaf", leaf_wleaf_seen, 64'h1234_5678_CAFE_F00D);

    // Best array
    n0 = best_rd_n;
    wb_xfer(1'b0, 32'h3003_0038, 32'h0, rd, lat);
    check("best_rd_lat", lat, 3);
    check("best_addr", best_addr_seen, 8'd7);
    check("best_rd_lo", rd, 32'hDEAD_BEEF);
    wb_xfer(1'b0, 32'h3003_003C, 32'h0, rd, lat);
    check("best_rd_hi", rd, 32'h1100_1010);
    n0 = best_rd_n;
    wb_xfer(1'b1, 32'h3003_0038, 32'h1234_5678, rd, lat);
    check("best_wr_acked", lat < 10, 1'b1);
    check("best_wr_no_strobe", best_rd_n - n0, 0);

    // Node tree at offset 2, then offset 63
    n1 = node_wr_n;
    wb_xfer(1'b1, 32'h3004_0002, 32'h0001_B801, rd, lat);
    check("node_wr_lat", lat, 2);
    check("node_wr_pulses", node_wr_n - n1, 1);
    check("node_wr_addr", node_addr_seen, 32'd2);
    check("node_wr_data", node_wdata_seen, 32'h0001_B801);
    wb_xfer(1'b0, 32'h3004_0002, 32'h0, rd, lat);
    check("node_rd_lat", lat, 3);
    check("node_rd", rd, 32'h0001_B801);
    repeat (3) @(negedge clk);
    check("dat_o_hold", dat_o, 32'h0001_B801);
    n1 = node_wr_n;
    wb_xfer(1'b1, 32'h3004_003F, 32'h0001_5002, rd, lat);
    check("node63_wr_pulses", node_wr_n - n1, 1);
    check("node63_wr_addr", node_addr_seen, 32'd63);
    wb_xfer(1'b0, 32'h3004_003F, 32'h0, rd, lat);
    check("node63_rd", rd, 32'h0001_5002);

    // Unmapped region and register offset
    wb_xfer(1'b0, 32'h3005_0000, 32'h0, rd, lat);
    check("unmapped_rd_lat", lat, 1);
    check("unmapped_rd", rd, 32'h0);
    wb_xfer(1'b1, 32'h3000_0010, 32'h0, rd, lat);
    check("unmapped_reg_wr", {mode, debug}, 2'b10);

    // Reset during a query read: strobe drops, no ack
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3001_0008;
    @(negedge clk);
    check("midrst_strobe_on", qp_csb, 1'b0);
    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    check("midrst_strobe_off", {qp_csb, ack}, 2'b10);
    @(posedge clk); #1;
    check("midrst_no_ack", ack, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_idle", {ack, mode, qp_csb}, 3'b001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
